// File: rtl/timebase_gen_if.sv
// Timebase bundle: count enable in, derived 1 s / 0.5 s waves and 10 s count out.
// Latency: n/a (wiring only); backpressure: none, all signals are free-running levels/pulses.
interface timebase_gen_if;
    logic       en_cnt_10s;
    logic       clk_1s;
    logic       tick_1s;
    logic       clk_half;
    logic [3:0] cnt_10s_val;
    logic       cnt_out_10s;

    modport master (
        input  en_cnt_10s,
        output clk_1s, tick_1s, clk_half, cnt_10s_val, cnt_out_10s
    );

    modport slave (
        output en_cnt_10s,
        input  clk_1s, tick_1s, clk_half, cnt_10s_val, cnt_out_10s
    );
endinterface

// File: rtl/timebase_gen.sv
// Timebase: 1 s and 0.5 s square waves plus a gated 10 s event counter, all on clk.
// Latency: outputs registered, counter advances the edge after tick_1s; backpressure: none.
module timebase_gen #(
    parameter int CLK_HZ    = 1_000_000,
    parameter int TEN_COUNT = 10
) (
    input  logic            clk,
    input  logic            rst,
    timebase_gen_if.master  tb
);
    localparam int HALF_HZ = CLK_HZ / 2;
    localparam int QTR_HZ  = CLK_HZ / 4;
    localparam int DW      = $clog2(HALF_HZ);

    localparam logic [DW-1:0] D1_MAX  = DW'(HALF_HZ - 1);
    localparam logic [DW-1:0] D2_MAX  = DW'(QTR_HZ - 1);
    localparam logic [3:0]    CNT_MAX = 4'(TEN_COUNT - 1);
    localparam logic [3:0]    CNT_PRE = 4'(TEN_COUNT - 2);

    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          clk_1s_q;
    logic          tick_q;
    logic          half_q;
    logic          half_run;
    logic [3:0]    cnt_q;
    logic          cnt_out_q;

    logic d1_wrap;
    logic d2_wrap;

    assign d1_wrap = (d1 == D1_MAX);
    assign d2_wrap = (d2 == D2_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            d1        <= '0;
            d2        <= '0;
            clk_1s_q  <= 1'b0;
            tick_q    <= 1'b0;
            half_q    <= 1'b0;
            half_run  <= 1'b0;
            cnt_q     <= '0;
            cnt_out_q <= 1'b0;
        end else begin
            d1     <= d1_wrap ? '0 : d1 + DW'(1);
            d2     <= d2_wrap ? '0 : d2 + DW'(1);
            tick_q <= d1_wrap & ~clk_1s_q;

            if (d1_wrap) begin
                clk_1s_q <= ~clk_1s_q;
                half_run <= 1'b1;
            end

            // Hold the half-second wave low until the first 1 s rise so both rise together.
            if (d2_wrap && (half_run || d1_wrap))
                half_q <= ~half_q;

            if (tick_q && tb.en_cnt_10s) begin
                cnt_q     <= (cnt_q == CNT_MAX) ? 4'd0 : cnt_q + 4'd1;
                cnt_out_q <= (cnt_q == CNT_PRE);
            end
        end
    end

    assign tb.clk_1s      = clk_1s_q;
    assign tb.tick_1s     = tick_q;
    assign tb.clk_half    = half_q;
    assign tb.cnt_10s_val = cnt_q;
    assign tb.cnt_out_10s = cnt_out_q;
endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen at CLK_HZ=8, TEN_COUNT=10 with an edge-indexed reference.
// Latency: n/a; backpressure: n/a.
module tb_timebase_gen;
    logic clk;
    logic rst;

    timebase_gen_if tbif ();

    timebase_gen #(
        .CLK_HZ   (8),
        .TEN_COUNT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tb (tbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int g      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, g, obs, exp);
        end
    endtask

    // Reference: m_edge = edges since reset release; waves follow directly from it.
    int         m_edge;
    logic       m_c1, m_half, m_tick, m_cout;
    logic [3:0] m_cnt;

    function automatic logic en_at(input int ge);
        int m;
        if (ge <= 90) begin
            m = ge - 3;
            return (m >= 9 && m <= 45) || (m >= 71);
        end
        return 1'b1;
    endfunction

    initial begin
        rst             = 1'b1;
        tbif.en_cnt_10s = 1'b0;
        m_edge = 0; m_c1 = 0; m_half = 0; m_tick = 0; m_cnt = 0; m_cout = 0;

        for (int e = 1; e <= 180; e++) begin
            logic prev_tick;
            g = e;
            rst             = (e <= 3) || (e == 89) || (e == 90);
            tbif.en_cnt_10s = en_at(e);
            @(posedge clk);
            #1;
            prev_tick = m_tick;
            if (rst) begin
                m_edge = 0; m_c1 = 0; m_half = 0; m_tick = 0; m_cnt = 0; m_cout = 0;
            end else begin
                m_edge++;
                m_c1   = ((m_edge / 4) % 2) == 1;
                m_half = (m_edge >= 4) && (((m_edge / 2) % 2) == 0);
                m_tick = (m_edge % 8) == 4;
                if (prev_tick && tbif.en_cnt_10s)
                    m_cnt = (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
                m_cout = (m_cnt == 4'd9);
            end
            chk("clk_1s",      32'(tbif.clk_1s),      32'(m_c1));
            chk("clk_half",    32'(tbif.clk_half),    32'(m_half));
            chk("tick_1s",     32'(tbif.tick_1s),     32'(m_tick));
            chk("cnt_10s_val", 32'(tbif.cnt_10s_val), 32'(m_cnt));
            chk("cnt_out_10s", 32'(tbif.cnt_out_10s), 32'(m_cout));

            // Hand-computed landmarks independent of the reference above.
            case (e)
                7:   chk("first_rise",    32'(tbif.clk_1s), 32'd1);
                11:  chk("first_fall",    32'(tbif.clk_1s), 32'd0);
                48:  chk("count_5",       32'(tbif.cnt_10s_val), 32'd5);
                73:  chk("frozen_5",      32'(tbif.cnt_10s_val), 32'd5);
                80:  chk("resume_6",      32'(tbif.cnt_10s_val), 32'd6);
                88:  chk("count_7",       32'(tbif.cnt_10s_val), 32'd7);
                89:  chk("mid_rst_clk",   32'(tbif.clk_1s), 32'd0);
                159: chk("reach_9",       32'(tbif.cnt_out_10s), 32'd1);
                167: chk("wrap_0",        32'(tbif.cnt_10s_val), 32'd0);
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
